// File: rtl/pixq_pkg.sv
// pixq_pkg: framebuffer geometry and pixel-entry type shared by the write queue and the VGA controller.
package pixq_pkg;
  localparam int FB_WIDTH = 640;
  localparam int FB_HEIGHT = 480;
  localparam int PIXQ_FB_SIZE = FB_WIDTH * FB_HEIGHT;
  localparam int PIXQ_FB_AW = $clog2(PIXQ_FB_SIZE);
  typedef struct packed {
    logic [PIXQ_FB_AW-1:0] addr;
    logic                  value;
  } pix_entry_t;
  function automatic logic in_fb_range(input logic [31:0] a, input int size);
    return a < 32'(size);
  endfunction
endpackage

// File: rtl/pixq_fifo.sv
// pixq_fifo: synchronous FIFO with level counter and in-place overwrite of the tail entry.
module pixq_fifo
  import pixq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W = PIXQ_FB_AW + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_ovr,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd, w_tail;
  logic [LW-1:0] r_level;
  assign w_tail  = r_wr - AW'(1);
  assign o_rdata = r_mem[r_rd];
  assign o_level = r_level;
  assign o_full  = r_level == LW'(DEPTH);
  assign o_empty = r_level == '0;
  // Storage carries no reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_wdata;
    else if (i_ovr) r_mem[w_tail] <= i_wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      r_wr    <= r_wr + AW'(i_push);
      r_rd    <= r_rd + AW'(i_pop);
      r_level <= r_level + LW'(i_push) - LW'(i_pop);
    end
  end
endmodule

// File: rtl/pixel_wr_queue.sv
// pixel_wr_queue: buffers core pixel stores and drains them to the framebuffer when fb_ready grants a slot.
// Define PIXQ_COALESCE_EN to merge a store to the current tail address into that entry.
module pixel_wr_queue
  import pixq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int FB_AW = PIXQ_FB_AW,
  parameter int FB_SIZE = PIXQ_FB_SIZE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pixel_en,
  input  logic [31:0]            pixel_addr,
  input  logic                   pixel_value,
  input  logic                   fb_ready,
  output logic                   fb_we,
  output logic [FB_AW-1:0]       fb_addr,
  output logic                   fb_data,
  output logic                   q_full,
  output logic                   q_empty,
  output logic [$clog2(DEPTH):0] q_level,
  output logic                   ovf,
  output logic                   range_err,
  input  logic                   err_clr
);
  localparam int LW = $clog2(DEPTH) + 1;
  logic [FB_AW:0]    w_head;
  logic [LW-1:0]     w_level;
  logic              w_full, w_empty, w_inr, w_req, w_pop, w_coal, w_push, w_drop;
  logic              r_fb_we, r_fb_data, r_ovf, r_range_err;
  logic [FB_AW-1:0]  r_fb_addr;
  assign w_inr  = in_fb_range(pixel_addr, FB_SIZE);
  assign w_req  = pixel_en && w_inr;
  assign w_pop  = fb_ready && !w_empty;
  assign w_push = w_req && !w_coal && (!w_full || w_pop);
  assign w_drop = w_req && !w_coal && w_full && !w_pop;
`ifdef PIXQ_COALESCE_EN
  logic [FB_AW-1:0] r_tail_addr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tail_addr <= '0;
    else if (w_push) r_tail_addr <= pixel_addr[FB_AW-1:0];
  end
  // A lone entry being popped this edge cannot be merged into; the store takes a fresh slot.
  assign w_coal = w_req && w_level != '0 && r_tail_addr == pixel_addr[FB_AW-1:0] &&
                  !(w_pop && w_level == LW'(1));
`else
  assign w_coal = 1'b0;
`endif
  pixq_fifo #(.DEPTH(DEPTH), .W(FB_AW + 1)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_ovr   (w_coal),
    .i_wdata ({pixel_addr[FB_AW-1:0], pixel_value}),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fb_we     <= 1'b0;
      r_fb_addr   <= '0;
      r_fb_data   <= 1'b0;
      r_ovf       <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_fb_we     <= w_pop;
      r_fb_addr   <= w_pop ? w_head[FB_AW:1] : r_fb_addr;
      r_fb_data   <= w_pop ? w_head[0] : r_fb_data;
      r_ovf       <= w_drop || (r_ovf && !err_clr);
      r_range_err <= (pixel_en && !w_inr) || (r_range_err && !err_clr);
    end
  end
  assign fb_we     = r_fb_we;
  assign fb_addr   = r_fb_addr;
  assign fb_data   = r_fb_data;
  assign q_level   = w_level;
  assign q_full    = w_full;
  assign q_empty   = w_empty && !r_fb_we;
  assign ovf       = r_ovf;
  assign range_err = r_range_err;
endmodule

// File: tb/tb_pixel_wr_queue.sv
// tb_pixel_wr_queue: directed self-checking bench for pixel_wr_queue (expectations follow PIXQ_COALESCE_EN).
module tb_pixel_wr_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pixel_en = 1'b0;
  logic [31:0] pixel_addr = '0;
  logic        pixel_value = 1'b0;
  logic        fb_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic        fb_we, fb_data, q_full, q_empty, ovf, range_err;
  logic [18:0] fb_addr;
  logic [3:0]  q_level;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pixel_wr_queue dut (
    .clk(clk), .rst_n(rst_n), .pixel_en(pixel_en), .pixel_addr(pixel_addr),
    .pixel_value(pixel_value), .fb_ready(fb_ready), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .q_full(q_full), .q_empty(q_empty), .q_level(q_level),
    .ovf(ovf), .range_err(range_err), .err_clr(err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_tests++; if (q_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", q_level); end
    n_tests++; if (q_empty !== 1'b1 || q_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", q_empty, q_full); end
    n_tests++; if (fb_we !== 1'b0 || fb_addr !== 19'd0 || fb_data !== 1'b0) begin n_fail++; $display("FAIL reset_out we=%b addr=%0d data=%b exp 0/0/0", fb_we, fb_addr, fb_data); end
    n_tests++; if (ovf !== 1'b0 || range_err !== 1'b0) begin n_fail++; $display("FAIL reset_err ovf=%b rerr=%b exp 0/0", ovf, range_err); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    fb_ready = 1'b1; pixel_en = 1'b1; pixel_addr = 32'd100; pixel_value = 1'b1;
    step();
    pixel_en = 1'b0;
    n_tests++; if (fb_we !== 1'b0 || q_level !== 4'd1 || q_empty !== 1'b0) begin n_fail++; $display("FAIL single_pushed we=%b lvl=%0d empty=%b exp 0/1/0", fb_we, q_level, q_empty); end
    step();
    n_tests++; if (fb_we !== 1'b1 || fb_addr !== 19'd100 || fb_data !== 1'b1) begin n_fail++; $display("FAIL single_issue we=%b addr=%0d data=%b exp 1/100/1", fb_we, fb_addr, fb_data); end
    n_tests++; if (q_level !== 4'd0 || q_empty !== 1'b0) begin n_fail++; $display("FAIL single_inflight lvl=%0d empty=%b exp 0/0", q_level, q_empty); end
    step();
    n_tests++; if (fb_we !== 1'b0 || q_empty !== 1'b1 || fb_addr !== 19'd100) begin n_fail++; $display("FAIL single_done we=%b empty=%b addr=%0d exp 0/1/100", fb_we, q_empty, fb_addr); end
  endtask

  task automatic test_full();
    fb_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pixel_en = 1'b1; pixel_addr = i; pixel_value = i[0];
      step();
    end
    pixel_en = 1'b0;
    n_tests++; if (q_level !== 4'd8 || q_full !== 1'b1) begin n_fail++; $display("FAIL full_level lvl=%0d full=%b exp 8/1", q_level, q_full); end
    n_tests++; if (ovf !== 1'b1 || fb_we !== 1'b0) begin n_fail++; $display("FAIL full_ovf ovf=%b we=%b exp 1/0", ovf, fb_we); end
    fb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_tests++; if (fb_we !== 1'b1 || fb_addr !== 19'(i) || fb_data !== i[0]) begin n_fail++; $display("FAIL full_drain%0d we=%b addr=%0d data=%b exp 1/%0d/%b", i, fb_we, fb_addr, fb_data, i, i[0]); end
    end
    step();
    n_tests++; if (fb_we !== 1'b0 || q_empty !== 1'b1) begin n_fail++; $display("FAIL full_lost8 we=%b empty=%b exp 0/1", fb_we, q_empty); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear ovf=%b exp 0", ovf); end
  endtask

  task automatic test_push_pop_full();
    logic [18:0] exp_a [8];
    fb_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pixel_en = 1'b1; pixel_addr = 200 + i; pixel_value = 1'b0;
      step();
    end
    n_tests++; if (q_full !== 1'b1) begin n_fail++; $display("FAIL pp_full full=%b exp 1", q_full); end
    fb_ready = 1'b1; pixel_addr = 32'd500; pixel_value = 1'b1;
    step();
    pixel_en = 1'b0;
    n_tests++; if (q_level !== 4'd8 || ovf !== 1'b0) begin n_fail++; $display("FAIL pp_accept lvl=%0d ovf=%b exp 8/0", q_level, ovf); end
    n_tests++; if (fb_we !== 1'b1 || fb_addr !== 19'd200) begin n_fail++; $display("FAIL pp_first we=%b addr=%0d exp 1/200", fb_we, fb_addr); end
    for (int i = 0; i < 7; i++) exp_a[i] = 19'(201 + i);
    exp_a[7] = 19'd500;
    for (int i = 0; i < 8; i++) begin
      step();
      n_tests++; if (fb_we !== 1'b1 || fb_addr !== exp_a[i] || fb_data !== (i == 7)) begin n_fail++; $display("FAIL pp_drain%0d we=%b addr=%0d data=%b exp 1/%0d/%b", i, fb_we, fb_addr, fb_data, exp_a[i], i == 7); end
    end
    step();
    n_tests++; if (q_empty !== 1'b1) begin n_fail++; $display("FAIL pp_empty empty=%b exp 1", q_empty); end
  endtask

  task automatic test_range();
    fb_ready = 1'b1; pixel_en = 1'b1; pixel_addr = 32'd307200; pixel_value = 1'b1;
    step();
    pixel_en = 1'b0;
    n_tests++; if (range_err !== 1'b1 || q_level !== 4'd0) begin n_fail++; $display("FAIL range_set rerr=%b lvl=%0d exp 1/0", range_err, q_level); end
    step();
    n_tests++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL range_nowrite we=%b exp 0", fb_we); end
    err_clr = 1'b1; pixel_en = 1'b1;
    step();
    pixel_en = 1'b0;
    n_tests++; if (range_err !== 1'b1) begin n_fail++; $display("FAIL range_clr_race rerr=%b exp 1", range_err); end
    step();
    err_clr = 1'b0;
    n_tests++; if (range_err !== 1'b0) begin n_fail++; $display("FAIL range_clr rerr=%b exp 0", range_err); end
    pixel_en = 1'b1; pixel_addr = 32'd307199;
    step();
    pixel_en = 1'b0;
    step();
    n_tests++; if (fb_we !== 1'b1 || fb_addr !== 19'd307199 || fb_data !== 1'b1 || range_err !== 1'b0) begin n_fail++; $display("FAIL range_edge we=%b addr=%0d data=%b rerr=%b exp 1/307199/1/0", fb_we, fb_addr, fb_data, range_err); end
    step();
  endtask

  task automatic test_async_reset();
    fb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pixel_en = 1'b1; pixel_addr = 10 + i; pixel_value = 1'b1;
      step();
    end
    pixel_en = 1'b0; fb_ready = 1'b1;
    step();
    n_tests++; if (fb_we !== 1'b1 || q_level !== 4'd4) begin n_fail++; $display("FAIL ar_drain we=%b lvl=%0d exp 1/4", fb_we, q_level); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (fb_we !== 1'b0 || q_level !== 4'd0 || q_empty !== 1'b1) begin n_fail++; $display("FAIL ar_immediate we=%b lvl=%0d empty=%b exp 0/0/1", fb_we, q_level, q_empty); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL ar_stale%0d we=%b exp 0", i, fb_we); end
    end
  endtask

  task automatic test_coalesce();
    fb_ready = 1'b0;
    pixel_en = 1'b1; pixel_addr = 32'd42; pixel_value = 1'b0;
    step();
    pixel_value = 1'b1;
    step();
    pixel_en = 1'b0;
`ifdef PIXQ_COALESCE_EN
    n_tests++; if (q_level !== 4'd1) begin n_fail++; $display("FAIL coal_level lvl=%0d exp 1", q_level); end
    fb_ready = 1'b1;
    step();
    n_tests++; if (fb_we !== 1'b1 || fb_addr !== 19'd42 || fb_data !== 1'b1) begin n_fail++; $display("FAIL coal_write we=%b addr=%0d data=%b exp 1/42/1", fb_we, fb_addr, fb_data); end
`else
    n_tests++; if (q_level !== 4'd2) begin n_fail++; $display("FAIL coal_level lvl=%0d exp 2", q_level); end
    fb_ready = 1'b1;
    step();
    n_tests++; if (fb_we !== 1'b1 || fb_addr !== 19'd42 || fb_data !== 1'b0) begin n_fail++; $display("FAIL coal_first we=%b addr=%0d data=%b exp 1/42/0", fb_we, fb_addr, fb_data); end
    step();
    n_tests++; if (fb_we !== 1'b1 || fb_addr !== 19'd42 || fb_data !== 1'b1) begin n_fail++; $display("FAIL coal_second we=%b addr=%0d data=%b exp 1/42/1", fb_we, fb_addr, fb_data); end
`endif
    step();
    n_tests++; if (fb_we !== 1'b0 || q_empty !== 1'b1) begin n_fail++; $display("FAIL coal_done we=%b empty=%b exp 0/1", fb_we, q_empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_push_pop_full();
    test_range();
    test_async_reset();
    test_coalesce();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_wr_queue.md
Name: pixel_wr_queue

Overview:
Sits directly downstream of the processor's pixel output port (pixel_en / pixel_addr / pixel_value). Buffers pixel writes in a small FIFO and drains them into the VGA framebuffer write port only when the framebuffer grants a write slot (fb_ready). Decouples instruction-rate pixel stores from display-timed framebuffer access. Flags full/overflow back to the core and status logic.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64
FB_AW, 19, framebuffer address width (640x480 = 307200 pixels)
FB_SIZE, 307200, number of valid pixel addresses; writes at or above it are dropped

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
pixel_en  in  1  one pixel write request per cycle high
pixel_addr  in  32  linear pixel address from core
pixel_value  in  1  pixel colour bit
fb_ready  in  1  framebuffer accepts a write on this edge (low during active-video reads)
fb_we  out  1  framebuffer write strobe, one cycle per pixel
fb_addr  out  FB_AW  framebuffer write address
fb_data  out  1  framebuffer write data
q_full  out  1  FIFO holds DEPTH entries
q_empty  out  1  FIFO holds 0 entries and no write pending on fb_we
q_level  out  $clog2(DEPTH)+1  current occupancy
ovf  out  1  sticky: a request was lost because the FIFO was full
range_err  out  1  sticky: a request had pixel_addr >= FB_SIZE
err_clr  in  1  synchronous clear of ovf and range_err

Behaviour:
- Reset (rst_n low, async): rd/wr pointers 0, q_level 0, q_full 0, q_empty 1, fb_we 0, fb_addr 0, fb_data 0, ovf 0, range_err 0. Reset mid-drain discards all queued entries; no partial write is emitted.
- Push: on edge with pixel_en=1 and pixel_addr < FB_SIZE, store {pixel_addr[FB_AW-1:0], pixel_value} at tail, unless full with no same-edge pop.
- Out of range: pixel_en=1 and pixel_addr >= FB_SIZE -> no push, range_err set on that edge.
- Pop/issue: on edge with fb_ready=1 and FIFO non-empty, head moves into output register; fb_we=1 for the following cycle with fb_addr/fb_data of that entry. Otherwise fb_we=0 next cycle; fb_addr/fb_data hold last value.
- Latency: push at edge k into empty FIFO, fb_ready high at edge k+1 -> fb_we high in cycle after edge k+1. No bypass: entry must be in FIFO one edge before issue.
- Order: strict FIFO; entries issue in push order, no reordering.
- Simultaneous push and pop: both take effect; q_level unchanged. When full, a same-edge pop makes room and the push is accepted (no ovf).
- Full with no pop: request dropped, ovf set, contents unchanged.
- err_clr: clears both sticky flags; a new error on the same edge wins (flag stays set).
- Pointers are $clog2(DEPTH) bits, wrap modulo DEPTH; full/empty derived from q_level counter.
- q_empty is high only when q_level=0 and fb_we=0, so software polling sees all writes landed.

Optional Feature:
PIXQ_COALESCE_EN. When defined: if pixel_en pushes an address equal to the current tail entry's address and that entry is not being popped on the same edge, overwrite its value in place. q_level is unchanged and no ovf occurs even when full. When undefined: every valid request takes its own entry.

Decomposition:
- Shared package pixq_pkg: FB_SIZE / FB_AW constants (640, 480, 307200) and entry struct {addr, value}, shared with the VGA controller.
- One natural sub-module: pixq_fifo (generic sync FIFO, storage + pointers + level). The top handles range check, sticky flags, output register and coalescing.

Test Plan:
- Reset then single write: pixel_en addr=100 value=1, fb_ready=1 -> fb_we=1, fb_addr=100, fb_data=1 exactly 2 cycles after request edge; q_empty returns to 1 the cycle after.
- Backpressure/full: fb_ready=0, 9 writes addr 0..8 -> q_level=8, q_full=1, ovf=1, addr 8 lost. Raise fb_ready -> addrs 0..7 emerge in order on 8 consecutive cycles.
- Push+pop when full: full FIFO, fb_ready=1 and pixel_en same edge addr=500 -> accepted, ovf stays 0, q_level stays 8.
- Range: addr=307200 -> no fb_we ever, range_err=1. err_clr pulse -> range_err=0. addr=307199 accepted normally.
- Async reset mid-drain: 5 queued, assert rst_n low between edges -> fb_we=0 and q_level=0 immediately; after release no stale writes issue.
- Coalesce (PIXQ_COALESCE_EN): fb_ready=0, write addr=42 val=0 then addr=42 val=1 -> q_level=1; drain gives single write 42/1. Without macro: q_level=2, writes 42/0 then 42/1.
